pc_unit: RTL and testbench

Parametrised program-counter unit for the 64-bit ARM pipeline, the successor to the plain PC register. It holds the fetch PC, presents it to the instruction fetch stage through a valid/ready handshake, and selects the next PC from sequential increment, taken branches, returns predicted by a small return-address stack (RAS), and exception entry. A boot/halt state machine controls when fetch requests are issued.

---
 rtl/pc_pkg.sv | 5 +
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_unit.sv | 83 ++++++++
 tb/tb_pc_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state and next-PC select encodings for the program-counter unit.
package pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
    typedef enum logic [2:0] {SEL_EXC, SEL_BR, SEL_RET, SEL_SEQ, SEL_HOLD} sel_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int DATA_WIDTH = 64,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [DATA_WIDTH-1:0]        link_i,
    output logic [DATA_WIDTH-1:0]        top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]         ptr_q, ptr_d, wr_idx;
    logic [PW:0]           count_q, count_d;
    logic                  empty, full;

    assign empty   = count_q == '0;
    assign full    = count_q == (PW+1)'(RAS_DEPTH);
    assign top_o   = mem_q[ptr_q - 1'b1];
    assign count_o = count_q;
    // push+pop replaces the current top instead of moving the pointer
    assign wr_idx  = pop_i ? ptr_q - 1'b1 : ptr_q;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (flush_i) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push_i && !pop_i) begin
            ptr_d   = ptr_q + 1'b1;
            count_d = full ? count_q : count_q + 1'b1;
        end else if (pop_i && !push_i && !empty) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_idx] <= link_i;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with boot/run/halt control, prioritised next-PC
// selection (exception, branch, RAS return, sequential) and fetch handshake.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'('h400),
    parameter int                    INSTR_BYTES  = 4,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_ready,
    output logic                        fetch_valid,
    output logic [DATA_WIDTH-1:0]       currentPc,
    input  logic                        branch_taken,
    input  logic [DATA_WIDTH-1:0]       branch_target,
    input  logic                        call,
    input  logic [DATA_WIDTH-1:0]       call_link,
    input  logic                        ret,
    input  logic                        exc_req,
    input  logic                        halt_req,
    input  logic                        resume,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INSTR_BYTES - 1);

    state_e                state_q, state_d;
    sel_e                  sel;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, raw_pc, ras_top;
    logic                  active, fire, has_ras;

    assign fetch_valid = state_q == RUN;
    assign currentPc   = pc_q;
    assign fire        = fetch_valid && fetch_ready;
    assign active      = state_q != HALTED;
    assign has_ras     = ras_count != '0;

    // only exc_req is honoured while halted
    assign sel = exc_req      ? SEL_EXC :
                 !active      ? SEL_HOLD :
                 branch_taken ? SEL_BR :
                 ret          ? SEL_RET :
                 fire         ? SEL_SEQ : SEL_HOLD;

    assign raw_pc = sel == SEL_EXC ? EXC_VECTOR :
                    sel == SEL_BR  ? branch_target :
                    sel == SEL_RET ? (has_ras ? ras_top : branch_target) :
                    sel == SEL_SEQ ? pc_q + DATA_WIDTH'(INSTR_BYTES) : pc_q;
    assign pc_d   = raw_pc & ALIGN_MASK;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = halt_req && !exc_req ? HALTED : RUN;
            HALTED:  state_d = resume || exc_req ? RUN : HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pc_ras #(.DATA_WIDTH(DATA_WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk     (clk),
        .rst     (reset),
        .push_i  (sel == SEL_BR && call),
        .pop_i   (sel == SEL_RET && has_ras),
        .flush_i (exc_req),
        .link_i  (call_link),
        .top_o   (ras_top),
        .count_o (ras_count)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit (64-bit default and a 32-bit instance for wrap).
module tb_pc_unit;
    logic        clk = 0;
    logic        reset = 1, reset_b = 1;
    logic        fetch_ready = 0, branch_taken = 0, call = 0, ret = 0;
    logic        exc_req = 0, halt_req = 0, resume = 0;
    logic [63:0] branch_target = '0, call_link = '0;
    logic        fetch_valid;
    logic [63:0] currentPc;
    logic [2:0]  ras_count;
    logic        ready_b = 0, br_b = 0, fv_b;
    logic [31:0] tgt_b = '0, pc_b;
    logic [2:0]  cnt_b;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .currentPc(currentPc), .branch_taken(branch_taken), .branch_target(branch_target),
        .call(call), .call_link(call_link), .ret(ret), .exc_req(exc_req),
        .halt_req(halt_req), .resume(resume), .ras_count(ras_count)
    );

    pc_unit #(.DATA_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset_b), .fetch_ready(ready_b), .fetch_valid(fv_b),
        .currentPc(pc_b), .branch_taken(br_b), .branch_target(tgt_b),
        .call(1'b0), .call_link(32'h0), .ret(1'b0), .exc_req(1'b0),
        .halt_req(1'b0), .resume(1'b0), .ras_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_pc", currentPc, 64'h0);
        chk("rst_fv", {63'b0, fetch_valid}, 64'h0);
        chk("rst_cnt", {61'b0, ras_count}, 64'h0);
        step();
        fetch_ready = 1;
        reset = 0;
        chk("boot_fv", {63'b0, fetch_valid}, 64'h0);
        step();
        chk("run_fv", {63'b0, fetch_valid}, 64'h1);
        chk("seq_pc0", currentPc, 64'h0);
        step(); chk("seq_pc4", currentPc, 64'h4);
        step(); chk("seq_pc8", currentPc, 64'h8);
        step(); chk("seq_pcC", currentPc, 64'hC);
        step(); chk("seq_pc10", currentPc, 64'h10);
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_pc", currentPc, 64'h10);
        end
        branch_taken = 1; branch_target = 64'h103;
        step(); chk("br_align", currentPc, 64'h100);
        call = 1; branch_target = 64'h200;
        for (int i = 0; i < 5; i++) begin
            call_link = 64'hA0 + 64'(i) * 64'h10;
            step();
            chk("call_pc", currentPc, 64'h200);
            chk("call_cnt", {61'b0, ras_count}, i < 4 ? 64'(i + 1) : 64'd4);
        end
        branch_taken = 0; call = 0; ret = 1; branch_target = 64'h300;
        step(); chk("ret_E0", currentPc, 64'hE0); chk("ret_cnt3", {61'b0, ras_count}, 64'd3);
        step(); chk("ret_D0", currentPc, 64'hD0);
        step(); chk("ret_C0", currentPc, 64'hC0);
        step(); chk("ret_B0", currentPc, 64'hB0); chk("ret_cnt0", {61'b0, ras_count}, 64'd0);
        step(); chk("ret_empty", currentPc, 64'h300); chk("ret_cnt_e", {61'b0, ras_count}, 64'd0);
        ret = 0; branch_taken = 1; call = 1; call_link = 64'h50; branch_target = 64'h600;
        step(); chk("push1_cnt", {61'b0, ras_count}, 64'd1);
        call = 0; exc_req = 1; ret = 1; halt_req = 1;
        step();
        chk("exc_pc", currentPc, 64'h400);
        chk("exc_run", {63'b0, fetch_valid}, 64'h1);
        chk("exc_flush", {61'b0, ras_count}, 64'd0);
        exc_req = 0; ret = 0; branch_taken = 0;
        step();
        chk("halt_fv", {63'b0, fetch_valid}, 64'h0);
        chk("halt_pc", currentPc, 64'h400);
        halt_req = 0; branch_taken = 1; branch_target = 64'h500; fetch_ready = 1;
        step(); chk("halt_ign_br", currentPc, 64'h400);
        branch_taken = 0; resume = 1;
        step(); chk("resume_fv", {63'b0, fetch_valid}, 64'h1); chk("resume_pc", currentPc, 64'h400);
        resume = 0;
        step(); chk("resume_seq", currentPc, 64'h404);
        step(); chk("resume_seq2", currentPc, 64'h408);
        #2 reset = 1;
        #2;
        chk("async_pc", currentPc, 64'h0);
        chk("async_fv", {63'b0, fetch_valid}, 64'h0);
        reset = 0;
        step();
        reset_b = 0;
        step(); chk("b_fv", {63'b0, fv_b}, 64'h1);
        br_b = 1; tgt_b = 32'hFFFF_FFFC;
        step(); chk("b_top", {32'b0, pc_b}, 64'hFFFF_FFFC);
        br_b = 0; ready_b = 1;
        step(); chk("b_wrap", {32'b0, pc_b}, 64'h0);
        step(); chk("b_after", {32'b0, pc_b}, 64'h4);
        #2 reset_b = 1;
        #2 chk("b_async", {32'b0, pc_b}, 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
